alu_seq_ctrl: RTL and testbench

Sequencer for the practice ALU. It takes the active-low pushbutton and the input switches, and steps through four phases: load operand A, load operand B, load opcode, then show the result. Each press loads the switches into the register for the current phase, so operands and opcode are entered one at a time. Once the opcode is loaded, it latches the combinational ALU result and flags for the display.

---
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Button-driven sequencer for the practice ALU: loads operand A, operand B and
// opcode from the switches on successive debounced presses, then latches the result.
module alu_seq_ctrl #(
   parameter int WIDTH      = 4,
   parameter int OPW        = 2,
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             na,
   input  logic [WIDTH-1:0] sw,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [OPW-1:0]   opcode,
   output logic [1:0]       phase,
   output logic [WIDTH-1:0] result_q,
   output logic [3:0]       flags_q,
   output logic             valid
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      SHOW    = 2'd3
   } state_t;

   logic          sync1_r, sync2_r;
   logic          a_s;
   logic          deb_r;
   logic [CW-1:0] cnt_r;
   logic          press_r;

   state_t        state_r, state_nxt_s;
   logic          load_a_s, load_b_s, load_op_s, clr_valid_s, capture_s;

   logic [WIDTH-1:0] op_a_r, op_b_r, result_r;
   logic [OPW-1:0]   opcode_r;
   logic [3:0]       flags_r;
   logic             valid_r;

   // two-flop synchronizer for the asynchronous pushbutton, idle state is released
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= na;
         sync2_r <= sync1_r;
      end
   end

   assign a_s = ~sync2_r;

   // debounce filter: a level change is accepted after DEB_CYCLES differing samples
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         deb_r   <= 1'b0;
         cnt_r   <= CNT_ZERO;
         press_r <= 1'b0;
      end else begin
         press_r <= 1'b0;
         if (a_s == deb_r) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r == CNT_MAX) begin
            deb_r   <= a_s;
            cnt_r   <= CNT_ZERO;
            press_r <= a_s;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // phase state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r <= LOAD_A;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-phase decode and register load strobes
   always_comb begin
      state_nxt_s = state_r;
      load_a_s    = 1'b0;
      load_b_s    = 1'b0;
      load_op_s   = 1'b0;
      clr_valid_s = 1'b0;
      case (state_r)
         LOAD_A: begin
            if (press_r) begin
               load_a_s    = 1'b1;
               state_nxt_s = LOAD_B;
            end else begin
               state_nxt_s = LOAD_A;
            end
         end
         LOAD_B: begin
            if (press_r) begin
               load_b_s    = 1'b1;
               state_nxt_s = LOAD_OP;
            end else begin
               state_nxt_s = LOAD_B;
            end
         end
         LOAD_OP: begin
            if (press_r) begin
               load_op_s   = 1'b1;
               state_nxt_s = SHOW;
            end else begin
               state_nxt_s = LOAD_OP;
            end
         end
         SHOW: begin
            if (press_r) begin
               clr_valid_s = 1'b1;
               state_nxt_s = LOAD_A;
            end else begin
               state_nxt_s = SHOW;
            end
         end
         default: begin
            state_nxt_s = LOAD_A;
         end
      endcase
   end

   // first SHOW cycle gives the ALU one clock to settle on the new opcode
   assign capture_s = (state_r == SHOW) && !valid_r && !press_r;

   // operand, opcode and result registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         op_a_r   <= {WIDTH{1'b0}};
         op_b_r   <= {WIDTH{1'b0}};
         opcode_r <= {OPW{1'b0}};
         result_r <= {WIDTH{1'b0}};
         flags_r  <= 4'b0000;
         valid_r  <= 1'b0;
      end else begin
         if (load_a_s) begin
            op_a_r <= sw;
         end
         if (load_b_s) begin
            op_b_r <= sw;
         end
         if (load_op_s) begin
            opcode_r <= sw[OPW-1:0];
         end
         if (clr_valid_s) begin
            valid_r <= 1'b0;
         end else if (capture_s) begin
            result_r <= alu_result;
            flags_r  <= alu_flags;
            valid_r  <= 1'b1;
         end
      end
   end

   assign op_a     = op_a_r;
   assign op_b     = op_b_r;
   assign opcode   = opcode_r;
   assign phase    = state_r;
   assign result_q = result_r;
   assign flags_q  = flags_r;
   assign valid    = valid_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl against a phase-level reference model of the
// operand/opcode/result sequence, with a small stand-in ALU driven from the DUT registers.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       nreset;
   logic       na;
   logic [3:0] sw;
   logic [3:0] alu_result;
   logic [3:0] alu_flags;
   logic [3:0] op_a, op_b, result_q, flags_q;
   logic [1:0] opcode, phase;
   logic       valid;

   int n_cmp_r = 0;
   int n_err_r = 0;

   // reference model state
   logic [3:0] m_a, m_b, m_res, m_flags;
   logic [1:0] m_op;
   int         m_phase;
   logic       m_valid;

   alu_seq_ctrl #(.WIDTH(4), .OPW(2), .DEB_CYCLES(4)) dut (
      .clk(clk), .nreset(nreset), .na(na), .sw(sw),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .phase(phase),
      .result_q(result_q), .flags_q(flags_q), .valid(valid)
   );

   always #5 clk = ~clk;

   // stand-in ALU: add/sub/and/xor; flags report only Z and C/borrow
   function automatic logic [3:0] alu_res(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [3:0] alu_flg(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int r;
      int c;
      r = int'(alu_res(a, b, op));
      c = 0;
      if (op == 2'd0) c = ((int'(a) + int'(b)) > 15) ? 1 : 0;
      if (op == 2'd1) c = (a < b) ? 1 : 0;
      return {1'b0, (r == 0), c[0], 1'b0};
   endfunction

   always_comb begin
      alu_result = alu_res(op_a, op_b, opcode);
      alu_flags  = alu_flg(op_a, op_b, opcode);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t reached, bench expected to finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp_r++;
      if (obs !== exp) begin
         n_err_r++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_a = 4'd0; m_b = 4'd0; m_op = 2'd0; m_res = 4'd0; m_flags = 4'd0;
      m_phase = 0; m_valid = 1'b0;
   endtask

   task automatic model_press(input logic [3:0] v);
      case (m_phase)
         0: m_a = v;
         1: m_b = v;
         2: begin
            m_op    = v[1:0];
            m_res   = alu_res(m_a, m_b, m_op);
            m_flags = alu_flg(m_a, m_b, m_op);
            m_valid = 1'b1;
         end
         default: m_valid = 1'b0;
      endcase
      m_phase = (m_phase + 1) % 4;
   endtask

   task automatic check_all();
      check("phase", phase, m_phase);
      check("op_a", op_a, m_a);
      check("op_b", op_b, m_b);
      check("opcode", opcode, m_op);
      check("result_q", result_q, m_res);
      check("flags_q", flags_q, m_flags);
      check("valid", valid, m_valid);
   endtask

   task automatic press(input logic [3:0] v, input bit bounce);
      bit found;
      int lat;
      sw = v;
      if (bounce) begin
         for (int i = 0; i < 10; i++) begin
            na = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
         end
         check("bounce_quiet", phase, m_phase);
      end
      na = 1'b0;
      found = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         tick();
         if (phase !== 2'(m_phase)) begin
            found = 1'b1;
            lat = i;
         end
      end
      check("press_seen", found, 1);
      if (!bounce) check("press_lat_in_6_8", (lat >= 6 && lat <= 8), 1);
      model_press(v);
      check("phase_step", phase, m_phase);
      if (m_phase == 3) begin
         check("valid_before_capture", valid, 0);
         tick();
      end
      check_all();
      repeat (12) tick();
      check("held_once", phase, m_phase);
      na = 1'b1;
      repeat (10) tick();
      check_all();
   endtask

   task automatic glitch(input int n);
      na = 1'b0;
      repeat (n) tick();
      na = 1'b1;
      repeat (10) tick();
      check_all();
   endtask

   initial begin
      bit found;
      int lat;
      logic [3:0] v;

      nreset = 1'b0; na = 1'b1; sw = 4'd0;
      model_reset();
      repeat (3) tick();
      check_all();
      nreset = 1'b1;
      tick();

      // directed sequence: 3 + 5 with opcode 0
      press(4'd3, 1'b0);
      press(4'd5, 1'b0);
      press(4'd0, 1'b0);
      check("seq_res", result_q, 8);
      check("seq_flags", flags_q, 0);
      check("seq_phase", phase, 3);
      glitch(3);
      press(4'd7, 1'b1);
      check("wrap_res", result_q, 8);
      check("wrap_valid", valid, 0);
      press(4'd9, 1'b0);
      check("wrap_op_a", op_a, 9);

      for (int k = 0; k < 24; k++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2) glitch($urandom_range(1, 3));
         else press(4'($urandom_range(0, 15)), r < 4);
      end

      // asynchronous reset mid-cycle
      @(posedge clk);
      #3 nreset = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      nreset = 1'b1;
      tick();

      // reset in LOAD_OP with the button held through it
      for (int k = 0; k < 3 && m_phase != 2; k++) press(4'($urandom_range(0, 15)), 1'b0);
      check("reach_load_op", phase, 2);
      v = 4'($urandom_range(1, 15));
      sw = v;
      na = 1'b0;
      repeat (3) tick();
      #2 nreset = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      tick();
      nreset = 1'b1;
      found = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         tick();
         if (phase !== 2'd0) begin
            found = 1'b1;
            lat = i;
         end
      end
      check("rst_press_seen", found, 1);
      check("rst_press_lat_in_6_8", (lat >= 6 && lat <= 8), 1);
      model_press(v);
      check_all();
      repeat (12) tick();
      check("rst_held_once", phase, 1);
      na = 1'b1;
      repeat (10) tick();
      check_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_r, n_err_r);
      $finish;
   end

endmodule
